// File: rtl/alu_pkg.sv
// Shared ALU encodings, request opcodes, flag positions and issue-FSM states.
// Imported by the issue controller and its handshake interface users.
package alu_pkg;

  localparam logic [3:0] I_ADD_1  = 4'h0;
  localparam logic [3:0] I_SUB_1  = 4'h1;
  localparam logic [3:0] I_ADD_AB = 4'h2;
  localparam logic [3:0] I_SUB_AB = 4'h3;
  localparam logic [3:0] I_ABS_A  = 4'h4;
  localparam logic [3:0] I_NEG_A  = 4'h5;
  localparam logic [3:0] I_NEG_B  = 4'h7;
  localparam logic [3:0] I_AND_AB = 4'h8;
  localparam logic [3:0] I_OR_AB  = 4'h9;
  localparam logic [3:0] I_XOR_AB = 4'hA;
  localparam logic [3:0] I_NOT_B  = 4'hB;
  localparam logic [3:0] I_A      = 4'hC;
  localparam logic [3:0] I_NOT_A  = 4'hD;
  localparam logic [3:0] I_0      = 4'hE;
  localparam logic [3:0] I_1      = 4'hF;

  typedef enum logic [1:0] {
    OP_SINGLE = 2'b00,
    OP_ADD    = 2'b01,
    OP_SUB    = 2'b10,
    OP_ILL    = 2'b11
  } op_e;

  localparam int F_ERR   = 3;
  localparam int F_RSVD  = 3;
  localparam int F_ZERO  = 2;
  localparam int F_CARRY = 1;
  localparam int F_OVF   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP_LO,
    S_STEP_HI,
    S_STEP_FIX,
    S_RSP
  } state_e;

  function automatic logic [3:0] wide_inst(op_e op);
    return (op == OP_SUB) ? I_SUB_AB : I_ADD_AB;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response valid-ready bundle between a requester and the
// ALU issue controller.
interface alu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_inst;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_z;
  logic [3:0]  rsp_flags;

  modport master (
    output req_valid, req_op, req_inst,
    output req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_z, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_inst,
    input  req_a, req_b, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_z, rsp_flags
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues single and 64-bit add/sub requests to a 32-bit ALU without
// carry-in; wide ops run lo, hi and an optional +/-1 fix-up step.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  alu_issue_ctrl_if.slave  bus,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_inst,
  input  logic [31:0]      alu_z,
  input  logic [3:0]       alu_flags
);

  localparam int CW = $clog2(ALU_LAT + 2);
  localparam logic [CW-1:0] LAT = CW'(ALU_LAT);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_e         op_q, op_d;
  logic [31:0] ahi_q, ahi_d;
  logic [31:0] bhi_q, bhi_d;
  logic [31:0] lo_q, lo_d;
  logic        zlo_q, zlo_d;
  logic        clo_q, clo_d;
  logic        c1_q, c1_d;
  logic        v1_q, v1_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_z_q, rsp_z_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_inst_q, alu_inst_d;
  logic        done;
  logic        fix;
  logic        carry;
  logic        unused_rsvd;

  assign unused_rsvd = alu_flags[F_RSVD];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ahi_d       = ahi_q;
    bhi_d       = bhi_q;
    lo_d        = lo_q;
    zlo_d       = zlo_q;
    clo_d       = clo_q;
    c1_d        = c1_q;
    v1_d        = v1_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_flags_d = rsp_flags_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_inst_d  = alu_inst_q;
    fix         = 1'b0;
    carry       = 1'b0;
    done        = (cnt_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d        = op_e'(bus.req_op);
          ahi_d       = bus.req_a[63:32];
          bhi_d       = bus.req_b[63:32];
          cnt_d       = LAT;
          req_ready_d = 1'b0;
          alu_a_d     = bus.req_a[31:0];
          alu_b_d     = bus.req_b[31:0];
          state_d     = S_STEP_LO;
          unique case (op_e'(bus.req_op))
            OP_SINGLE: alu_inst_d = bus.req_inst;
            OP_ADD:    alu_inst_d = I_ADD_AB;
            OP_SUB:    alu_inst_d = I_SUB_AB;
            OP_ILL: begin
              alu_a_d     = '0;
              alu_b_d     = '0;
              rsp_z_d     = '0;
              rsp_flags_d = 4'b1000;
              rsp_valid_d = 1'b1;
              state_d     = S_RSP;
            end
            default: ;
          endcase
        end
      end

      S_STEP_LO: begin
        if (!done) begin
          cnt_d = cnt_q - CW'(1);
        end else if (op_q == OP_SINGLE) begin
          rsp_z_d     = {32'b0, alu_z};
          rsp_flags_d = {1'b0, alu_flags[2:0]};
          rsp_valid_d = 1'b1;
          alu_a_d     = '0;
          alu_b_d     = '0;
          alu_inst_d  = I_ADD_AB;
          state_d     = S_RSP;
        end else begin
          lo_d       = alu_z;
          zlo_d      = alu_flags[F_ZERO];
          clo_d      = alu_flags[F_CARRY];
          alu_a_d    = ahi_q;
          alu_b_d    = bhi_q;
          alu_inst_d = wide_inst(op_q);
          cnt_d      = LAT;
          state_d    = S_STEP_HI;
        end
      end

      S_STEP_HI: begin
        if (!done) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          c1_d = alu_flags[F_CARRY];
          v1_d = alu_flags[F_OVF];
          // sub carry is no-borrow, so a clear lo carry means borrow
          fix  = (op_q == OP_ADD) ? clo_q : !clo_q;
          if (fix) begin
            alu_a_d    = alu_z;
            alu_b_d    = '0;
            alu_inst_d = (op_q == OP_ADD) ? I_ADD_1 : I_SUB_1;
            cnt_d      = LAT;
            state_d    = S_STEP_FIX;
          end else begin
            rsp_z_d     = {alu_z, lo_q};
            rsp_flags_d = {1'b0, zlo_q & alu_flags[F_ZERO],
                           alu_flags[F_CARRY], alu_flags[F_OVF]};
            rsp_valid_d = 1'b1;
            alu_a_d     = '0;
            alu_b_d     = '0;
            alu_inst_d  = I_ADD_AB;
            state_d     = S_RSP;
          end
        end
      end

      S_STEP_FIX: begin
        if (!done) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          carry = (op_q == OP_ADD) ?
                  (c1_q | alu_flags[F_CARRY]) :
                  (c1_q & alu_flags[F_CARRY]);
          rsp_z_d     = {alu_z, lo_q};
          rsp_flags_d = {1'b0, zlo_q & alu_flags[F_ZERO],
                         carry, v1_q ^ alu_flags[F_OVF]};
          rsp_valid_d = 1'b1;
          alu_a_d     = '0;
          alu_b_d     = '0;
          alu_inst_d  = I_ADD_AB;
          state_d     = S_RSP;
        end
      end

      S_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_SINGLE;
      ahi_q       <= '0;
      bhi_q       <= '0;
      lo_q        <= '0;
      zlo_q       <= 1'b0;
      clo_q       <= 1'b0;
      c1_q        <= 1'b0;
      v1_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_flags_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_inst_q  <= I_ADD_AB;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ahi_q       <= ahi_d;
      bhi_q       <= bhi_d;
      lo_q        <= lo_d;
      zlo_q       <= zlo_d;
      clo_q       <= clo_d;
      c1_q        <= c1_d;
      v1_q        <= v1_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_flags_q <= rsp_flags_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_inst_q  <= alu_inst_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_inst      = alu_inst_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench: issue controller plus a behavioural registered-input
// ALU, with hand-computed responses and per-cycle ALU_INST traces.
module tb_alu_issue_ctrl;

  logic        clock;
  logic        reset_n;
  logic [31:0] alu_a, alu_b, alu_z;
  logic [3:0]  alu_inst, alu_flags;
  int          checks;
  int          errors;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.ALU_LAT(1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_inst  (alu_inst),
    .alu_z     (alu_z),
    .alu_flags (alu_flags)
  );

  // ALU: inputs registered, result combinational
  logic [31:0] la, lb;
  logic [3:0]  li;
  logic [32:0] r;
  logic        c, v;

  initial begin
    la = '0;
    lb = '0;
    li = 4'h2;
  end

  always @(posedge clock) begin
    la <= alu_a;
    lb <= alu_b;
    li <= alu_inst;
  end

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (li)
      4'h0: begin
        r = {1'b0, la} + 33'd1;
        c = r[32];
        v = ~la[31] & r[31];
      end
      4'h1: begin
        r = {1'b0, la} - 33'd1;
        c = (la != 32'd0);
        v = la[31] & ~r[31];
      end
      4'h2: begin
        r = {1'b0, la} + {1'b0, lb};
        c = r[32];
        v = (la[31] == lb[31]) && (r[31] != la[31]);
      end
      4'h3: begin
        r = {1'b0, la} - {1'b0, lb};
        c = (la >= lb);
        v = (la[31] != lb[31]) && (r[31] != la[31]);
      end
      4'h8: r = {1'b0, la & lb};
      4'h9: r = {1'b0, la | lb};
      4'hA: r = {1'b0, la ^ lb};
      default: r = {1'b0, la};
    endcase
    alu_z     = r[31:0];
    alu_flags = {1'b0, (r[31:0] == 32'd0), c, v};
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends one request; returns per-cycle ALU_INST trace and cycle count
  task automatic do_req(input  logic [1:0]  op,
                        input  logic [3:0]  inst,
                        input  logic [63:0] a,
                        input  logic [63:0] b,
                        output logic [31:0] trace,
                        output int          n);
    int w;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      cyc();
      w++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_inst  = inst;
    bus.req_a     = a;
    bus.req_b     = b;
    cyc();
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    trace = '0;
    n = 0;
    while (n < 20) begin
      trace = {trace[27:0], alu_inst};
      n++;
      if (bus.rsp_valid) break;
      cyc();
    end
  endtask

  task automatic take_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    chk({tag, "_vld_clr"}, {63'd0, bus.rsp_valid}, 64'd0);
    chk({tag, "_rdy_set"}, {63'd0, bus.req_ready}, 64'd1);
  endtask

  logic [31:0] tr;
  int          n;
  logic [63:0] held_z;

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_inst  = 4'h0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_z", bus.rsp_z, 64'd0);
    chk("rst_flags", {60'd0, bus.rsp_flags}, 64'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    chk("rst_alu_inst", {60'd0, alu_inst}, 64'h2);
    reset_n = 1'b1;
    cyc();

    // single add 5+7, then backpressure for 5 cycles
    do_req(2'b00, 4'h2, 64'd5, 64'd7, tr, n);
    chk("s_add_trace", {32'd0, tr}, 64'h222);
    chk("s_add_cycles", 64'(n), 64'd3);
    chk("s_add_z", bus.rsp_z, 64'h0000_0000_0000_000C);
    chk("s_add_flags", {60'd0, bus.rsp_flags}, 64'h0);
    held_z = bus.rsp_z;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_z", bus.rsp_z, held_z);
      chk("bp_req_ready", {63'd0, bus.req_ready}, 64'd0);
    end
    take_rsp("s_add");

    // single AND to zero: zero flag, upper half cleared
    do_req(2'b00, 4'h8, 64'hFFFF_FFFF_0000_00F0, 64'hFFFF_FFFF_0000_000F, tr, n);
    chk("s_and_z", bus.rsp_z, 64'd0);
    chk("s_and_flags", {60'd0, bus.rsp_flags}, 64'h4);
    take_rsp("s_and");

    // wide add with lo carry into hi
    do_req(2'b01, 4'hF, 64'h0000_0000_FFFF_FFFF, 64'd1, tr, n);
    chk("w_add_trace", {32'd0, tr}, 64'h222_2002);
    chk("w_add_cycles", 64'(n), 64'd7);
    chk("w_add_z", bus.rsp_z, 64'h0000_0001_0000_0000);
    chk("w_add_flags", {60'd0, bus.rsp_flags}, 64'h0);
    take_rsp("w_add");

    // wide sub with borrow from hi
    do_req(2'b10, 4'hF, 64'h0000_0001_0000_0000, 64'd1, tr, n);
    chk("w_sub_trace", {32'd0, tr}, 64'h333_3112);
    chk("w_sub_z", bus.rsp_z, 64'h0000_0000_FFFF_FFFF);
    chk("w_sub_flags", {60'd0, bus.rsp_flags}, 64'h2);
    take_rsp("w_sub");

    // wide add: hi overflows, fix-up overflows back
    do_req(2'b01, 4'h0, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, tr, n);
    chk("w_ovf_trace", {32'd0, tr}, 64'h222_2002);
    chk("w_ovf_z", bus.rsp_z, 64'h8000_0000_0000_0000);
    chk("w_ovf_flags", {60'd0, bus.rsp_flags}, 64'h2);
    take_rsp("w_ovf");

    // wide add 0+0: no fix-up, zero flag from both halves
    do_req(2'b01, 4'h0, 64'd0, 64'd0, tr, n);
    chk("w_zero_trace", {32'd0, tr}, 64'h2_2222);
    chk("w_zero_cycles", 64'(n), 64'd5);
    chk("w_zero_z", bus.rsp_z, 64'd0);
    chk("w_zero_flags", {60'd0, bus.rsp_flags}, 64'h4);
    take_rsp("w_zero");

    // wide sub no borrow
    do_req(2'b10, 4'h0, 64'd5, 64'd3, tr, n);
    chk("w_sub2_trace", {32'd0, tr}, 64'h3_3332);
    chk("w_sub2_z", bus.rsp_z, 64'd2);
    chk("w_sub2_flags", {60'd0, bus.rsp_flags}, 64'h2);
    take_rsp("w_sub2");

    // illegal opcode
    do_req(2'b11, 4'h3, 64'd9, 64'd9, tr, n);
    chk("ill_trace", {32'd0, tr}, 64'h2);
    chk("ill_cycles", 64'(n), 64'd1);
    chk("ill_z", bus.rsp_z, 64'd0);
    chk("ill_flags", {60'd0, bus.rsp_flags}, 64'h8);
    chk("ill_alu_ab", {alu_a, alu_b}, 64'd0);
    take_rsp("ill");

    // reset while the hi step of a wide add is in flight
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_a     = 64'h0000_0003_FFFF_FFFF;
    bus.req_b     = 64'h0000_0004_0000_0001;
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    cyc();
    chk("mid_hi_alu_a", {32'd0, alu_a}, 64'h3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_inst", {60'd0, alu_inst}, 64'h2);
    chk("mid_rst_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("mid_rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_ab", {alu_a, alu_b}, 64'd0);
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("mid_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    end

    // recovery after reset
    do_req(2'b00, 4'hA, 64'h0000_00FF, 64'h0000_0F0F, tr, n);
    chk("post_xor_z", bus.rsp_z, 64'h0000_0000_0000_0FF0);
    chk("post_xor_flags", {60'd0, bus.rsp_flags}, 64'h0);
    take_rsp("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Requester-side controller for the functional-unit ALU.
- Accepts 32-bit single operations and 64-bit add/subtract requests over a valid/ready port, and drives the ALU operand/instruction inputs.
- Captures the ALU result and flags after the ALU's register latency and returns a response over a valid/ready port.
- Provides the 64-bit capability the ALU lacks: the ALU has no carry-in, so 64-bit add/sub is run as a 2–3 step ALU sequence.

Parameters:
ALU_LAT, 1, clock edges from the ALU latching its inputs until ALU_Z/ALU_FLAGS are valid (ALU registers inputs, output combinational)

Ports:
CLOCK  input  1  clock
RESET_N  input  1  asynchronous active-low reset
REQ_VALID  input  1  request valid
REQ_READY  output  1  request accepted when VALID&READY at posedge
REQ_OP  input  2  00 single, 01 wide add, 10 wide sub, 11 illegal
REQ_INST  input  4  ALU instruction for single op (ignored otherwise)
REQ_A  input  64  operand A (single uses [31:0])
REQ_B  input  64  operand B (single uses [31:0])
RSP_VALID  output  1  response valid
RSP_READY  input  1  response consumed when VALID&READY at posedge
RSP_Z  output  64  result (single: [63:32]=0)
RSP_FLAGS  output  4  {error, zero, carry, overflow}
ALU_A  output  32  to ALU A
ALU_B  output  32  to ALU B
ALU_INST  output  4  to ALU INST
ALU_Z  input  32  from ALU Z
ALU_FLAGS  input  4  from ALU FLAGS {rsvd, zero, carry, ovf}

Behaviour:
- Reset (async, RESET_N low):
  - State IDLE.
  - REQ_READY=1, RSP_VALID=0, RSP_Z=0, RSP_FLAGS=0.
  - ALU_A=0, ALU_B=0, ALU_INST=4'h2 (add 0+0, the idle op).
- All outputs are registered.
- One operation in flight. REQ_READY=1 only in IDLE.
- ALU step:
  - At edge e, registered ALU_A/B/INST are updated.
  - At edge e+1 the ALU latches them.
  - ALU_Z/ALU_FLAGS are sampled at edge e+1+ALU_LAT; with default 1, that is 2 edges after issue.
  - A down-counter sized for ALU_LAT+1 times the wait.
- States: IDLE, STEP_LO, STEP_HI, STEP_FIX, RSP.
- IDLE, on accept:
  - Latch request.
  - Single: issue REQ_INST, A[31:0], B[31:0] → STEP_LO.
  - Wide add: issue 4'h2, A[31:0], B[31:0] → STEP_LO.
  - Wide sub: issue 4'h3, A[31:0], B[31:0] → STEP_LO.
  - Illegal: → RSP with RSP_Z=0, RSP_FLAGS=4'b1000, no ALU activity.
- STEP_LO sample:
  - Single: RSP_Z={32'b0, Z}, RSP_FLAGS={1'b0, ALU_FLAGS[2:0]} → RSP.
  - Wide: store lo, z_lo, c_lo; issue the same INST with A[63:32], B[63:32] → STEP_HI.
- STEP_HI sample: store hi, z1, c1, v1.
  - Fix needed when (add & c_lo) or (sub & !c_lo). The ALU carry for sub is no-borrow.
  - If fix needed: issue INST add_1 (4'h0) for add or sub_1 (4'h1) for sub, with A=hi, B=0 → STEP_FIX.
  - Otherwise → RSP with z=z1, c=c1, v=v1.
- STEP_FIX sample (hi'=Z, z2, c2, v2) → RSP with:
  - hi=hi'
  - zero = z2
  - add: carry = c1|c2
  - sub: carry = c1&c2
  - overflow = v1^v2
- Wide RSP values: RSP_Z={hi, lo}; RSP_FLAGS={0, z_lo&zero_hi, carry, overflow}.
- Idle ALU drive: after the final sample, ALU_A/B/INST return to 0/0/4'h2.
- RSP state:
  - RSP_VALID=1; RSP_Z and RSP_FLAGS are held stable until RSP_READY.
  - On handshake: RSP_VALID=0 and REQ_READY=1 at the same edge → IDLE.
  - A new request is accepted no earlier than the following edge.
- Reset mid-operation: in-flight op discarded, no response, all outputs to reset values.
- REQ_VALID while busy: ignored; the requester must hold it.
- Carry/ovf semantics are those of the ALU for a 32-bit single op.

Decomposition:
- Shared package alu_pkg:
  - ALU instruction localparams: add_1=0, sub_1=1, add_ab=2, sub_ab=3, abs_a=4, neg_a=5, neg_b=7, and_ab=8, or_ab=9, xor_ab=A, not_b=B, i_a=C, not_a=D, i_0=E, i_1=F.
  - REQ_OP encodings.
  - FLAGS bit indices.
  - FSM state enum.
- No sub-module required. A bench wrapper instantiates alu_issue_ctrl plus Alu.

Test Plan:
1. Single REQ_INST=2, A=5, B=7 → RSP_Z=0x0000000C after 2-edge ALU step; FLAGS=0000; ALU_INST sequence 2.
2. Wide add A=0x00000000_FFFFFFFF, B=1 → ALU_INST 2,2,0; RSP_Z=0x00000001_00000000; FLAGS=0000.
3. Wide sub A=0x00000001_00000000, B=1 → ALU_INST 3,3,1; RSP_Z=0x00000000_FFFFFFFF; FLAGS=0010 (no borrow).
4. Wide add A=0x80000000_00000001, B=0xFFFFFFFF_FFFFFFFF → RSP_Z=0x80000000_00000000; carry=1, overflow=0 (v1^v2); zero=0.
5. Backpressure: hold RSP_READY=0 for 5 cycles → RSP_VALID/RSP_Z stable, REQ_READY=0; then release → RSP_VALID=0, REQ_READY=1 at the same edge.
6. REQ_OP=11 → RSP_FLAGS=1000, RSP_Z=0, ALU_INST stays 2. Separately, reset asserted during STEP_HI of a wide add → no response, ALU_INST=2, REQ_READY=1 immediately.
